// File: rtl/hash_byte_feeder_pkg.sv
// Shared types for the hash byte feeder: FSM state encoding, byte/digest
// typedefs and default sizing.
package hash_feeder_pkg;
  localparam int DEF_DEPTH   = 64;
  localparam int DEF_TIMEOUT = 4096;

  typedef logic [7:0]  byte_t;
  typedef logic [31:0] digest_t;

  typedef enum logic [2:0] {
    IDLE, START, REQ, REL, EOFW, EOF, WAITH, DONE
  } feeder_state_t;
endpackage

// File: rtl/hash_byte_feeder_if.sv
// Host and core bus of the hash byte feeder.
//   host: host_wr_en/host_wr_data (FIFO load), host_full, host_send, host_busy,
//         host_digest/host_digest_valid/host_digest_ack, host_timeout
//   core: start, Byte, End_of_File, F_dr (source side), F_rtr, R_h, H_ready
// master = feeder, slave = host + core as seen from outside.
interface hash_byte_feeder_if;
  import hash_feeder_pkg::*;

  logic        host_wr_en;
  byte_t       host_wr_data;
  logic        host_full;
  logic        host_send;
  logic        host_busy;
  digest_t     host_digest;
  logic        host_digest_valid;
  logic        host_digest_ack;
  logic        host_timeout;
  logic        start;
  byte_t       Byte;
  logic        End_of_File;
  logic        F_dr;
  logic        F_rtr;
  logic [0:31] R_h;
  logic        H_ready;

  modport master (
    input  host_wr_en, host_wr_data, host_send, host_digest_ack, F_rtr, R_h, H_ready,
    output host_full, host_busy, host_digest, host_digest_valid, host_timeout,
           start, Byte, End_of_File, F_dr
  );

  modport slave (
    output host_wr_en, host_wr_data, host_send, host_digest_ack, F_rtr, R_h, H_ready,
    input  host_full, host_busy, host_digest, host_digest_valid, host_timeout,
           start, Byte, End_of_File, F_dr
  );
endinterface

// File: rtl/hash_byte_feeder_byte_fifo.sv
// byte_fifo: synchronous circular byte buffer.
//   push/wdata : write (ignored when full)
//   pop        : advance head (ignored when empty)
//   flush      : empty the buffer, wins over push/pop
//   rdata      : current head byte (combinational)
//   count/full/empty : occupancy
// DEPTH is a power of 2, so the AW-bit pointers wrap on their own.
module byte_fifo
  import hash_feeder_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  byte_t       wdata,
  input  logic        pop,
  input  logic        flush,
  output byte_t       rdata,
  output logic [AW:0] count,
  output logic        full,
  output logic        empty
);
  byte_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/hash_byte_feeder.sv
// hash_byte_feeder: source side of the full_hash byte-stream protocol.
// The host fills the byte FIFO while idle and pulses host_send; the feeder
// issues start, streams each byte with the F_dr/F_rtr four-phase handshake,
// signals End_of_File, then captures R_h on H_ready and holds it until
// host_digest_ack. Any core-wait state lasting TIMEOUT cycles aborts the
// message, flushes the FIFO and raises the sticky host_timeout.
//   clk, rst_n : clock, async active-low reset
//   bus        : host + core signals (hash_byte_feeder_if.master)
module hash_byte_feeder
  import hash_feeder_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int AW      = $clog2(DEPTH),
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hash_byte_feeder_if.master   bus
);
  localparam int TW = $clog2(TIMEOUT + 1);

  feeder_state_t state_q, state_d;
  logic [AW:0]   rem_q, fifo_cnt;
  logic [TW-1:0] tcnt_q;
  byte_t         byte_q, head;
  digest_t       digest_q;
  logic          valid_q, tmo_q;
  logic          push, pop, tmo, waiting, fifo_full, fifo_empty;

  // Loading is only allowed between messages; anything else is dropped.
  assign push    = (state_q == IDLE) && bus.host_wr_en && !fifo_full;
  assign waiting = (state_q inside {REQ, REL, EOFW, EOF, WAITH});

  byte_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (bus.host_wr_data),
    .pop   (pop),
    .flush (tmo),
    .rdata (head),
    .count (fifo_cnt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    tmo     = 1'b0;
    case (state_q)
      IDLE:  if (bus.host_send) state_d = START;
      START: state_d = (rem_q != '0 && !fifo_empty) ? REQ : EOFW;
      // Pop on the REQ->REL edge so the head already points at the next
      // byte when REL hands back to REQ.
      REQ:   if (bus.F_rtr) begin
               state_d = REL;
               pop     = 1'b1;
             end
      REL:   if (!bus.F_rtr) state_d = (rem_q != '0) ? REQ : EOFW;
      EOFW:  if (bus.F_rtr) state_d = EOF;
      EOF:   if (!bus.F_rtr) state_d = WAITH;
      WAITH: if (bus.H_ready) state_d = DONE;
      DONE:  if (bus.host_digest_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A pending transition wins; abort only when stuck for the full budget.
    if (waiting && state_d == state_q && tcnt_q == TW'(TIMEOUT - 1)) begin
      state_d = IDLE;
      pop     = 1'b0;
      tmo     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q    <= '0;
      tcnt_q   <= '0;
      byte_q   <= '0;
      digest_q <= '0;
      valid_q  <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      if (state_d != state_q) tcnt_q <= '0;
      else if (waiting)       tcnt_q <= tcnt_q + 1'b1;

      // Snapshot includes a byte written in the same cycle as host_send.
      if (state_q == IDLE && bus.host_send) begin
        rem_q <= fifo_cnt + (AW+1)'(push);
        tmo_q <= 1'b0;
      end
      if (pop) rem_q <= rem_q - 1'b1;

      if (state_d == REQ && state_q != REQ) byte_q <= head;

      if (tmo) begin
        tmo_q  <= 1'b1;
        byte_q <= '0;
      end

      // R_h is [0:31]; a direct assignment puts R_h[0] on digest bit 31.
      if (state_q == WAITH && bus.H_ready) begin
        digest_q <= bus.R_h;
        valid_q  <= 1'b1;
      end
      if (state_q == DONE && bus.host_digest_ack) valid_q <= 1'b0;
    end
  end

  assign bus.host_full         = fifo_full;
  assign bus.host_busy         = (state_q != IDLE);
  assign bus.host_digest       = digest_q;
  assign bus.host_digest_valid = valid_q;
  assign bus.host_timeout      = tmo_q;
  assign bus.start             = (state_q == START);
  assign bus.F_dr              = (state_q == REQ);
  assign bus.End_of_File       = (state_q == EOF);
  assign bus.Byte              = byte_q;
endmodule

// File: tb/tb_hash_byte_feeder.sv
// Directed bench for hash_byte_feeder with a small behavioural core that
// answers the F_dr / End_of_File handshakes and presents H_ready.
module tb_hash_byte_feeder;
  import hash_feeder_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int TMO   = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hash_byte_feeder_if bus();

  hash_byte_feeder #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // core model state (written only by the core process)
  byte_t log_b [512];
  int    log_idx   = 0;
  int    start_cnt = 0;
  int    eof_cnt   = 0;
  int    inv_bad   = 0;
  int    phase     = 2;
  logic  core_en   = 1'b1;

  byte_t exp_b [$];
  int    b0, s0, e0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Core: raise F_rtr on F_dr (logging Byte), drop it when F_dr falls; raise
  // it in EOFW, drop it on End_of_File, then present H_ready until valid.
  initial begin : core
    bus.F_rtr   = 1'b0;
    bus.H_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.F_dr && bus.End_of_File) inv_bad++;
      if (bus.start) begin
        start_cnt++;
        phase = 0;
      end
      if (!core_en) begin
        bus.F_rtr   = 1'b0;
        bus.H_ready = 1'b0;
        phase       = 2;
      end else begin
        if (bus.F_rtr) begin
          if (bus.End_of_File) begin
            eof_cnt++;
            bus.F_rtr = 1'b0;
            phase     = 1;
          end else if (!bus.F_dr) bus.F_rtr = 1'b0;
        end else if (bus.F_dr) begin
          log_b[log_idx] = bus.Byte;
          log_idx++;
          bus.F_rtr = 1'b1;
        end else if (phase == 0 && bus.host_busy && !bus.start) begin
          bus.F_rtr = 1'b1;
        end
        if (phase == 1) begin
          if (bus.host_digest_valid) begin
            bus.H_ready = 1'b0;
            phase       = 2;
          end else bus.H_ready = 1'b1;
        end
      end
    end
  end

  task automatic push_byte(input byte_t b);
    bus.host_wr_en   = 1'b1;
    bus.host_wr_data = b;
    @(negedge clk);
    bus.host_wr_en   = 1'b0;
  endtask

  task automatic push_all();
    foreach (exp_b[i]) push_byte(exp_b[i]);
  endtask

  task automatic send();
    b0 = log_idx;
    s0 = start_cnt;
    e0 = eof_cnt;
    bus.host_send = 1'b1;
    @(negedge clk);
    bus.host_send = 1'b0;
  endtask

  task automatic wait_bytes(input string tag, input int n);
    int k = 0;
    while (log_idx - b0 < n && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(log_idx - b0 >= n), 32'd1);
  endtask

  task automatic finish_msg(input string tag, input digest_t d);
    int n = 0;
    while (!bus.host_digest_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " valid"}, 32'(bus.host_digest_valid), 32'd1);
    chk({tag, " nbytes"}, 32'(log_idx - b0), 32'(exp_b.size()));
    for (int i = 0; i < exp_b.size() && i < log_idx - b0; i++)
      chk({tag, " byte"}, 32'(log_b[b0 + i]), 32'(exp_b[i]));
    chk({tag, " starts"}, 32'(start_cnt - s0), 32'd1);
    chk({tag, " eofs"}, 32'(eof_cnt - e0), 32'd1);
    chk({tag, " digest"}, bus.host_digest, d);
    chk({tag, " fdr&eof"}, 32'(inv_bad), 32'd0);
    repeat (4) @(negedge clk);
    chk({tag, " valid held"}, 32'(bus.host_digest_valid), 32'd1);
    bus.host_digest_ack = 1'b1;
    @(negedge clk);
    bus.host_digest_ack = 1'b0;
    chk({tag, " valid clr"}, 32'(bus.host_digest_valid), 32'd0);
    chk({tag, " idle"}, 32'(bus.host_busy), 32'd0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int k;
    bus.host_wr_en      = 1'b0;
    bus.host_wr_data    = '0;
    bus.host_send       = 1'b0;
    bus.host_digest_ack = 1'b0;
    bus.R_h             = '0;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst busy", 32'(bus.host_busy), 32'd0);
    chk("rst flags", 32'({bus.start, bus.F_dr, bus.End_of_File, bus.host_digest_valid,
                          bus.host_timeout, bus.host_full}), 32'd0);
    chk("rst digest", bus.host_digest, 32'd0);
    chk("rst byte", 32'(bus.Byte), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // "CiaoMondo": latency, order, R_h bit mapping
    exp_b = '{8'h43, 8'h69, 8'h61, 8'h6F, 8'h4D, 8'h6F, 8'h6E, 8'h64, 8'h6F};
    push_all();
    chk("ciao full", 32'(bus.host_full), 32'd0);
    bus.R_h    = '0;
    bus.R_h[0] = 1'b1;
    bus.R_h[4] = 1'b1;
    send();
    chk("lat start", 32'(bus.start), 32'd1);
    chk("lat fdr0", 32'(bus.F_dr), 32'd0);
    @(negedge clk);
    chk("lat fdr", 32'(bus.F_dr), 32'd1);
    chk("lat byte", 32'(bus.Byte), 32'h43);
    finish_msg("ciao", 32'h8800_0000);

    // empty message
    exp_b.delete();
    bus.R_h = 32'h1234_5678;
    send();
    finish_msg("empty", 32'h1234_5678);

    // reset after byte 4
    exp_b = '{8'h43, 8'h69, 8'h61, 8'h6F, 8'h4D, 8'h6F, 8'h6E, 8'h64, 8'h6F};
    push_all();
    send();
    wait_bytes("rst reach4", 4);
    core_en = 1'b0;
    rst_n   = 1'b0;
    #1;
    chk("midrst flags", 32'({bus.start, bus.F_dr, bus.End_of_File, bus.host_busy,
                             bus.host_digest_valid, bus.host_timeout}), 32'd0);
    chk("midrst byte", 32'(bus.Byte), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    core_en = 1'b1;
    @(negedge clk);
    chk("midrst count", 32'(dut.u_fifo.count), 32'd0);
    chk("midrst busy", 32'(bus.host_busy), 32'd0);
    push_all();
    bus.R_h = 32'hCAFE_F00D;
    send();
    finish_msg("reload", 32'hCAFE_F00D);

    // host_send / host_wr_en while streaming
    push_all();
    bus.R_h = 32'h0F0F_0001;
    send();
    wait_bytes("busy reach2", 2);
    bus.host_send    = 1'b1;
    bus.host_wr_en   = 1'b1;
    bus.host_wr_data = 8'hFF;
    @(negedge clk);
    bus.host_send    = 1'b0;
    bus.host_wr_en   = 1'b0;
    finish_msg("busy", 32'h0F0F_0001);
    chk("busy fifo", 32'(dut.u_fifo.count), 32'd0);

    // core never answers F_dr -> timeout
    core_en = 1'b0;
    exp_b = '{8'h01, 8'h02, 8'h03};
    push_all();
    send();
    k = 0;
    while (!bus.host_timeout && k < TMO + 50) begin
      @(negedge clk);
      k++;
    end
    chk("tmo flag", 32'(bus.host_timeout), 32'd1);
    chk("tmo fdr", 32'(bus.F_dr), 32'd0);
    chk("tmo busy", 32'(bus.host_busy), 32'd0);
    chk("tmo count", 32'(dut.u_fifo.count), 32'd0);
    core_en = 1'b1;
    @(negedge clk);
    exp_b = '{8'h55, 8'hAA};
    push_all();
    bus.R_h = 32'h0000_00FF;
    send();
    chk("tmo clr", 32'(bus.host_timeout), 32'd0);
    finish_msg("post tmo", 32'h0000_00FF);

    // DEPTH+1 writes, then a second full fill to exercise pointer wrap
    exp_b.delete();
    for (int i = 0; i < DEPTH; i++) exp_b.push_back(byte_t'(8'h10 + i));
    push_all();
    chk("full flag", 32'(bus.host_full), 32'd1);
    push_byte(8'h99);
    chk("full count", 32'(dut.u_fifo.count), 32'(DEPTH));
    bus.R_h = 32'hA5A5_5A5A;
    send();
    finish_msg("full", 32'hA5A5_5A5A);
    exp_b.delete();
    for (int i = 0; i < DEPTH; i++) exp_b.push_back(byte_t'(8'hA0 + i));
    push_all();
    chk("wrap full", 32'(bus.host_full), 32'd1);
    bus.R_h = 32'h0000_0001;
    send();
    finish_msg("wrap", 32'h0000_0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
